// File: rtl/dual_issue_sequencer.sv
// Holds one fetched instruction pair, checks intra-pair hazards and issues
// it as one dual issue or as two single issues, with flush and statistics.
module dual_issue_sequencer #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_inst2,
  input  logic             in_v2,
  input  logic [4:0]       in_dst1,
  input  logic [4:0]       in_dst2,
  input  logic             in_wen1,
  input  logic             in_wen2,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rt2,
  input  logic             in_mem1,
  input  logic             in_mem2,
  input  logic             in_br1,
  input  logic             in_br2,
  input  logic             iss_ready,
  output logic             iss0_valid,
  output logic             iss1_valid,
  output logic [31:0]      iss0_inst,
  output logic [31:0]      iss1_inst,
  output logic [PC_W-1:0]  iss0_pc,
  output logic [PC_W-1:0]  iss1_pc,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] split_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HALF  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PC_W-1:0]  pc_q;
  logic [31:0]      inst1_q, inst2_q;
  logic [4:0]       dst1_q, rs2_q, rt2_q;
  logic             v2_q, wen1_q;
  logic             mem1_q, mem2_q, br1_q, br2_q;
  logic [CNT_W-1:0] dual_q, dual_d;
  logic [CNT_W-1:0] split_q, split_d;

  logic raw, strct, split, last, accept;

  // WAW between the two slots is harmless for in-order issue
  logic unused_waw;
  assign unused_waw = ^{in_dst2, in_wen2};

  assign raw = wen1_q & (dst1_q != 5'd0) &
               ((dst1_q == rs2_q) | (dst1_q == rt2_q));
  assign strct = (mem1_q & mem2_q) | (br1_q & br2_q);
  assign split = v2_q & (raw | strct);

  assign last = ((state_q == FULL) & ~split) | (state_q == HALF);
  assign in_ready = ~flush &
                    ((state_q == EMPTY) | (iss_ready & last));
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    dual_d  = dual_q;
    split_d = split_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = FULL;
        FULL: begin
          if (iss_ready) begin
            if (split) begin
              state_d = HALF;
              if (split_q != '1) split_d = split_q + CNT_W'(1);
            end else begin
              state_d = accept ? FULL : EMPTY;
              if (v2_q && dual_q != '1) dual_d = dual_q + CNT_W'(1);
            end
          end
        end
        HALF: if (iss_ready) state_d = accept ? FULL : EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      dual_q  <= '0;
      split_q <= '0;
    end else begin
      state_q <= state_d;
      dual_q  <= dual_d;
      split_q <= split_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst1_q <= '0;
      inst2_q <= '0;
      v2_q    <= 1'b0;
      dst1_q  <= '0;
      wen1_q  <= 1'b0;
      rs2_q   <= '0;
      rt2_q   <= '0;
      mem1_q  <= 1'b0;
      mem2_q  <= 1'b0;
      br1_q   <= 1'b0;
      br2_q   <= 1'b0;
    end else if (accept) begin
      pc_q    <= in_pc;
      inst1_q <= in_inst1;
      inst2_q <= in_inst2;
      v2_q    <= in_v2;
      dst1_q  <= in_dst1;
      wen1_q  <= in_wen1;
      rs2_q   <= in_rs2;
      rt2_q   <= in_rt2;
      mem1_q  <= in_mem1;
      mem2_q  <= in_mem2;
      br1_q   <= in_br1;
      br2_q   <= in_br2;
    end
  end

  assign iss0_valid = (state_q != EMPTY);
  assign iss0_inst  = (state_q == HALF) ? inst2_q : inst1_q;
  assign iss0_pc    = (state_q == HALF) ? pc_q + PC_W'(4) : pc_q;
  assign iss1_valid = (state_q == FULL) & ~split & v2_q;
  assign iss1_inst  = inst2_q;
  assign iss1_pc    = pc_q + PC_W'(4);
  assign dual_cnt   = dual_q;
  assign split_cnt  = split_q;

endmodule

// File: tb/tb_dual_issue_sequencer.sv
// Bench for dual_issue_sequencer: pair table with issue scoreboard,
// plus directed split, stall, flush, saturation and async-reset sequences.
module tb_dual_issue_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready;
  logic [31:0]   in_pc, in_inst1, in_inst2;
  logic          in_v2, in_wen1, in_wen2;
  logic [4:0]    in_dst1, in_dst2, in_rs2, in_rt2;
  logic          in_mem1, in_mem2, in_br1, in_br2;
  logic          iss_ready;
  logic          iss0_valid, iss1_valid;
  logic [31:0]   iss0_inst, iss1_inst, iss0_pc, iss1_pc;
  logic [CW-1:0] dual_cnt, split_cnt;

  dual_issue_sequencer #(.CNT_W(CW), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst1(in_inst1), .in_inst2(in_inst2),
    .in_v2(in_v2), .in_dst1(in_dst1), .in_dst2(in_dst2),
    .in_wen1(in_wen1), .in_wen2(in_wen2),
    .in_rs2(in_rs2), .in_rt2(in_rt2),
    .in_mem1(in_mem1), .in_mem2(in_mem2),
    .in_br1(in_br1), .in_br2(in_br2),
    .iss_ready(iss_ready),
    .iss0_valid(iss0_valid), .iss1_valid(iss1_valid),
    .iss0_inst(iss0_inst), .iss1_inst(iss1_inst),
    .iss0_pc(iss0_pc), .iss1_pc(iss1_pc),
    .dual_cnt(dual_cnt), .split_cnt(split_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, i1, i2;
    logic        v2;
    logic [4:0]  d1;
    logic        w1;
    logic [4:0]  d2;
    logic        w2;
    logic [4:0]  rs, rt;
    logic        m1, m2, b1, b2;
    logic        sp;
  } vec_t;

  typedef struct {
    logic [31:0] i0, p0;
    logic        v1;
    logic [31:0] i1, p1;
  } exp_t;

  exp_t    q[$];
  vec_t    vt[12];
  int      n_vec = 0;
  int      n_bad = 0;
  bit      mon_en = 0;
  int      md = 0;
  int      ms = 0;

  function automatic vec_t mkv(
    input logic [31:0] pc, i1, i2,
    input logic v2,
    input logic [4:0] d1, input logic w1,
    input logic [4:0] d2, input logic w2,
    input logic [4:0] rs, rt,
    input logic m1, m2, b1, b2, sp);
    vec_t v;
    v.pc = pc; v.i1 = i1; v.i2 = i2; v.v2 = v2;
    v.d1 = d1; v.w1 = w1; v.d2 = d2; v.w2 = w2;
    v.rs = rs; v.rt = rt;
    v.m1 = m1; v.m2 = m2; v.b1 = b1; v.b2 = b2;
    v.sp = sp;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? x : x + 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_pc = v.pc; in_inst1 = v.i1; in_inst2 = v.i2;
    in_v2 = v.v2; in_dst1 = v.d1; in_wen1 = v.w1;
    in_dst2 = v.d2; in_wen2 = v.w2;
    in_rs2 = v.rs; in_rt2 = v.rt;
    in_mem1 = v.m1; in_mem2 = v.m2;
    in_br1 = v.b1; in_br2 = v.b2;
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    bit   ok;
    ok = 0;
    drive(v);
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL accept_timeout pc=%0h got in_ready=0 want 1", v.pc);
    end
    e.i0 = v.i1; e.p0 = v.pc;
    e.v1 = v.v2 & ~v.sp;
    e.i1 = v.i2; e.p1 = v.pc + 32'd4;
    q.push_back(e);
    if (v.sp) begin
      e.i0 = v.i2; e.p0 = v.pc + 32'd4;
      e.v1 = 1'b0; e.i1 = '0; e.p1 = '0;
      q.push_back(e);
      ms = sat(ms);
    end else if (v.v2) begin
      md = sat(md);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !iss0_valid) begin ok = 1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_timeout got q=%0d want 0", q.size());
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && iss0_valid && iss_ready && !flush) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_issue got inst=%0h want none",
                 iss0_inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (iss0_inst !== e.i0 || iss0_pc !== e.p0 ||
            iss1_valid !== e.v1 ||
            (e.v1 && (iss1_inst !== e.i1 || iss1_pc !== e.p1))) begin
          n_bad++;
          $display("FAIL issue got %0h@%0h v1=%0b %0h@%0h want %0h@%0h v1=%0b %0h@%0h",
                   iss0_inst, iss0_pc, iss1_valid, iss1_inst, iss1_pc,
                   e.i0, e.p0, e.v1, e.i1, e.p1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vt[0]  = mkv(32'h100, 32'h002081b3, 32'h402082b3, 1,
                 3, 1, 5, 1, 1, 2, 0, 0, 0, 0, 0);
    vt[1]  = mkv(32'h200, 32'h11000001, 32'h11000002, 1,
                 8, 1, 9, 1, 8, 1, 0, 0, 0, 0, 1);
    vt[2]  = mkv(32'h300, 32'h12000001, 32'h12000002, 1,
                 9, 1, 4, 1, 2, 9, 0, 0, 0, 0, 1);
    vt[3]  = mkv(32'h400, 32'h13000001, 32'h13000002, 1,
                 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    vt[4]  = mkv(32'h500, 32'h14000001, 32'h14000002, 1,
                 7, 0, 4, 1, 7, 7, 0, 0, 0, 0, 0);
    vt[5]  = mkv(32'h600, 32'h15000001, 32'h15000002, 1,
                 6, 1, 7, 1, 1, 2, 1, 1, 0, 0, 1);
    vt[6]  = mkv(32'h700, 32'h16000001, 32'h16000002, 1,
                 6, 1, 7, 1, 1, 2, 1, 0, 0, 0, 0);
    vt[7]  = mkv(32'h800, 32'h17000001, 32'h17000002, 1,
                 0, 0, 0, 0, 1, 2, 0, 0, 1, 1, 1);
    vt[8]  = mkv(32'h900, 32'h18000001, 32'h18000002, 1,
                 0, 0, 3, 1, 1, 2, 0, 0, 1, 0, 0);
    vt[9]  = mkv(32'ha00, 32'h19000001, 32'h19000002, 1,
                 4, 1, 4, 1, 1, 2, 0, 0, 0, 0, 0);
    vt[10] = mkv(32'hb00, 32'h1a000001, 32'h1a000002, 0,
                 8, 1, 0, 0, 8, 8, 0, 0, 0, 0, 0);
    vt[11] = mkv(32'hc00, 32'h1b000001, 32'h1b000002, 0,
                 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b1;
    drive(vt[0]);
    #23;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_iss0_valid", 64'(iss0_valid), 64'd0);
    chk("reset_iss1_valid", 64'(iss1_valid), 64'd0);
    chk("reset_dual_cnt", 64'(dual_cnt), 64'd0);
    chk("reset_split_cnt", 64'(split_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    mon_en = 1;
    for (int i = 0; i < 12; i++) send(vt[i]);
    drain();
    chk("table_dual_cnt", 64'(dual_cnt), 64'(md));
    chk("table_split_cnt", 64'(split_cnt), 64'(ms));
    mon_en = 0;

    @(posedge clk); #1;
    v = vt[1];
    drive(v); in_valid = 1'b1;
    @(negedge clk);
    chk("raw_accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("raw_c1_iss0", 64'(iss0_inst), 64'(v.i1));
    chk("raw_c1_iss1_valid", 64'(iss1_valid), 64'd0);
    chk("raw_c1_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("raw_c2_iss0", 64'(iss0_inst), 64'(v.i2));
    chk("raw_c2_pc", 64'(iss0_pc), 64'(v.pc + 32'd4));
    chk("raw_c2_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("raw_done", 64'(iss0_valid), 64'd0);
    ms = sat(ms);
    chk("raw_split_cnt", 64'(split_cnt), 64'(ms));

    @(posedge clk); #1;
    v = vt[0];
    iss_ready = 1'b0;
    drive(v); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_iss0", 64'(iss0_inst), 64'(v.i1));
      chk("stall_iss1_valid", 64'(iss1_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    chk("stall_dual_cnt", 64'(dual_cnt), 64'(md));
    @(posedge clk); #1; iss_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_iss1_pc", 64'(iss1_pc), 64'(v.pc + 32'd4));
    @(negedge clk);
    chk("release_once", 64'(iss0_valid), 64'd0);
    md = sat(md);
    chk("release_dual_cnt", 64'(dual_cnt), 64'(md));

    @(posedge clk); #1;
    v = vt[2];
    drive(v); in_valid = 1'b1;
    @(posedge clk); #1;
    drive(vt[0]);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_half_iss0", 64'(iss0_inst), 64'(v.i2));
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_iss0_valid", 64'(iss0_valid), 64'd0);
    chk("flush_iss1_valid", 64'(iss1_valid), 64'd0);
    @(negedge clk);
    chk("flush_no_inst2", 64'(iss0_valid), 64'd0);
    ms = sat(ms);
    chk("flush_split_cnt", 64'(split_cnt), 64'(ms));
    chk("flush_dual_cnt", 64'(dual_cnt), 64'(md));

    @(posedge clk); #1;
    mon_en = 1;
    for (int i = 0; i < 20; i++) send(vt[i % 2 == 0 ? 0 : 9]);
    drain();
    mon_en = 0;
    chk("sat_dual_cnt", 64'(dual_cnt), 64'(md));
    chk("sat_all_ones", 64'(dual_cnt), 64'((1 << CW) - 1));

    @(posedge clk); #1;
    iss_ready = 1'b0;
    drive(vt[0]); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_valid", 64'(iss0_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_iss0_valid", 64'(iss0_valid), 64'd0);
    chk("arst_iss1_valid", 64'(iss1_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_dual_cnt", 64'(dual_cnt), 64'd0);
    chk("arst_split_cnt", 64'(split_cnt), 64'd0);
    #3 rst = 1'b0;
    iss_ready = 1'b1;
    @(negedge clk);
    chk("arst_dropped", 64'(iss0_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_sequencer.md
Name: dual_issue_sequencer

Overview:
- Sits between the fetch pair buffer and the dual instruction decoder/issue stage.
- Holds one fetched instruction pair and checks intra-pair hazards.
- Issues both instructions in one cycle when legal; otherwise splits the pair over two cycles: slot 0 first, the remainder next.
- Provides valid/ready flow control on both sides, a synchronous flush, and saturating dual/split statistics counters.

Parameters:
CNT_W, 16, width of the dual_cnt and split_cnt statistics counters
PC_W, 32, width of the program counter

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  reset; asynchronous, active-high
flush  input  1  synchronous discard of the held pair (branch mispredict/exception)
in_valid  input  1  fetch offers a pair
in_ready  output  1  sequencer accepts the pair this cycle
in_pc  input  PC_W  PC of instruction 1; instruction 2 is at in_pc+4
in_inst1, in_inst2  input  32  raw instruction words
in_v2  input  1  instruction 2 present (0 means a single-instruction fetch)
in_dst1, in_dst2  input  5  destination register
in_wen1, in_wen2  input  1  register write enable
in_rs2, in_rt2  input  5  source registers of instruction 2
in_mem1, in_mem2  input  1  load/store
in_br1, in_br2  input  1  branch/jump
iss_ready  input  1  downstream accepts the issue this cycle
iss0_valid, iss1_valid  output  1  issue slot valid
iss0_inst, iss1_inst  output  32  instruction issued in each slot
iss0_pc, iss1_pc  output  PC_W  PC of the instruction in each slot
dual_cnt, split_cnt  output  CNT_W  statistics counters

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to EMPTY.
  - Holding register is cleared.
  - All iss*_valid = 0, in_ready = 1, and both counters = 0.
  - Reset mid-operation drops any held pair with no issue.
- States:
  - EMPTY: nothing held.
  - FULL: pair held, nothing issued yet.
  - HALF: only instruction 2 remains.
- Hazard terms, computed from the held fields:
  - raw = wen1 & (dst1 != 0) & ((dst1 == rs2) | (dst1 == rt2))
  - struct = (mem1 & mem2) | (br1 & br2)
  - split = v2 & (raw | struct)
- Outputs are a function of state and the held register only; there is no combinational path from in_* to iss_*.
- FULL, no split:
  - iss0 = inst1 at pc; iss1_valid = v2, with iss1 = inst2 at pc+4.
  - If iss_ready: next state is EMPTY or reload; dual_cnt increments when v2 = 1.
- FULL, split:
  - iss0 = inst1 only; iss1_valid = 0.
  - If iss_ready: next state is HALF and split_cnt increments.
- HALF: iss0 = inst2 at pc+4; iss1_valid = 0. If iss_ready: next state is EMPTY or reload.
- in_ready = (state == EMPTY) | (iss_ready & the current issue is the last one for the pair), and is forced to 0 while flush = 1.
  - Accept happens when in_valid & in_ready; the next state is then FULL with the new pair captured.
  - This allows back-to-back pairs with no bubble.
- Latency: a pair accepted in cycle N is first visible on iss0 in cycle N+1.
- Stall: while iss_ready = 0, all iss outputs hold stable and the state does not change.
- flush:
  - Highest priority after rst.
  - Next state is EMPTY and the held pair is discarded; no input is accepted that cycle.
  - Issue outputs in the flush cycle are still presented, but downstream ignores them.
  - Counters keep their values.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- A register 0 destination never creates a RAW hazard.
- WAW between dst1 and dst2 is not a hazard: in-order issue preserves program order.
- Branch in slot 1 with its delay slot in slot 2 dual-issues unless another hazard applies.

Test Plan:
- Independent pair (pc = 0x100, add r3 / sub r5 with sources r1, r2), iss_ready = 1 -> next cycle iss0 = inst1 at 0x100 and iss1 = inst2 at 0x104, both valid; dual_cnt = 1; in_ready stays 1.
- RAW pair (dst1 = 8, wen1 = 1, rs2 = 8) -> cycle 1 iss0 = inst1 with iss1_valid = 0; cycle 2 iss0 = inst2 at pc+4; split_cnt = 1; in_ready = 0 in cycle 1 and 1 in cycle 2.
- dst1 = 0 with rs2 = 0, and separately two loads (mem1 = mem2 = 1) -> first dual-issues; second splits and split_cnt increments.
- iss_ready held low 3 cycles in FULL -> outputs stable, no state change, in_ready = 0; release -> issue proceeds exactly once.
- flush asserted while in HALF -> next cycle all valids are 0 and state is EMPTY; the held inst2 is never issued; counters unchanged.
- in_v2 = 0 single instruction -> only iss0 valid and neither counter changes. Also: preload dual_cnt to all-ones, then issue an independent pair -> dual_cnt stays saturated. Also: assert rst asynchronously mid-FULL -> valids drop immediately.
